// File: rtl/vga_button_control_pkg.sv
// Shared constants and types for the VGA pipeline: timing of the visible
// area, button debounce default and image selection width.
package vga_button_control_pkg;

  // Visible area, shared with the scanline and image drivers.
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_V_ACTIVE = 480;

  // 10 ms of stability at a 25 MHz pixel clock.
  localparam int PIXEL_CLK_HZ        = 25_000_000;
  localparam int DEBOUNCE_MS         = 10;
  localparam int DEBOUNCE_CYCLES_DEF = (PIXEL_CLK_HZ / 1000) * DEBOUNCE_MS;

  // Number of selectable images and the index type that addresses them.
  localparam int IMAGE_COUNT_DEF = 3;
  localparam int IMAGE_IDX_W     = $clog2(IMAGE_COUNT_DEF);
  typedef logic [IMAGE_IDX_W-1:0] image_idx_t;

endpackage : vga_button_control_pkg

// File: rtl/vga_button_control_if.sv
// Button/vsync inputs and committed frame controls of the button stage.
// The slave side is the control block; the master side drives the buttons
// and vsync and consumes the committed controls.
interface vga_button_control_if
  import vga_button_control_pkg::*;
#(
  parameter int IMAGE_COUNT = IMAGE_COUNT_DEF
);

  logic                           i_CYCLE_IMAGE;
  logic                           i_BLANK_DISPLAY;
  logic                           i_VGA_VSYNC;
  logic [$clog2(IMAGE_COUNT)-1:0] o_IMAGE_SEL;
  logic                           o_BLANK;
  logic                           o_FRAME_COMMIT;

  modport master (
    output i_CYCLE_IMAGE, i_BLANK_DISPLAY, i_VGA_VSYNC,
    input  o_IMAGE_SEL, o_BLANK, o_FRAME_COMMIT
  );

  modport slave (
    input  i_CYCLE_IMAGE, i_BLANK_DISPLAY, i_VGA_VSYNC,
    output o_IMAGE_SEL, o_BLANK, o_FRAME_COMMIT
  );

endinterface : vga_button_control_if

// File: rtl/button_debouncer.sv
// Two-flop synchronizer, stability counter and one-cycle press pulse for a
// single raw mechanical button. Internally pressed is always 1.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES   = 250_000,
  parameter bit BUTTON_ACTIVE_LOW = 1'b1
) (
  input  logic i_CLK,
  input  logic i_RST_N,
  input  logic btn_raw_i,
  output logic press_o
);

  localparam int              CNT_W        = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic            RAW_RELEASED = BUTTON_ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             synced;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  // Polarity normalised after the synchronizer: 1 means pressed.
  assign synced  = sync_q[1] ^ RAW_RELEASED;
  assign press_o = press_q;

  // Count consecutive disagreeing cycles; flip the level after the full run.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (synced != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = synced;
        press_d = synced;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchronizer, debounced level, counter and press pulse registers.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (!i_RST_N) begin
      sync_q  <= {2{RAW_RELEASED}};
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_raw_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

endmodule : button_debouncer

// File: rtl/vga_button_control.sv
// Button control stage for the VGA pipeline: debounces the cycle and blank
// buttons, holds requests pending and commits them only at the falling edge
// of vsync so a displayed frame never changes mid-frame.
module vga_button_control
  import vga_button_control_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEF,
  parameter int IMAGE_COUNT       = IMAGE_COUNT_DEF,
  parameter bit BUTTON_ACTIVE_LOW = 1'b1
) (
  input logic                 i_CLK,
  input logic                 i_RST_N,
  vga_button_control_if.slave bus
);

  localparam int              IDX_W    = $clog2(IMAGE_COUNT);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(IMAGE_COUNT - 1);

  logic             press_cycle, press_blank;
  logic             vsync_q;
  logic             boundary;
  logic             pend_cycle_q, pend_cycle_d;
  logic             pend_blank_q, pend_blank_d;
  logic [IDX_W-1:0] img_q, img_d;
  logic             blank_q, blank_d;
  logic             commit_q, commit_d;

  button_debouncer #(
    .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
    .BUTTON_ACTIVE_LOW(BUTTON_ACTIVE_LOW)
  ) u_cycle_btn (
    .i_CLK    (i_CLK),
    .i_RST_N  (i_RST_N),
    .btn_raw_i(bus.i_CYCLE_IMAGE),
    .press_o  (press_cycle)
  );

  button_debouncer #(
    .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
    .BUTTON_ACTIVE_LOW(BUTTON_ACTIVE_LOW)
  ) u_blank_btn (
    .i_CLK    (i_CLK),
    .i_RST_N  (i_RST_N),
    .btn_raw_i(bus.i_BLANK_DISPLAY),
    .press_o  (press_blank)
  );

  // Frame boundary: vsync was high last cycle and is low now.
  assign boundary = vsync_q & ~bus.i_VGA_VSYNC;

  assign bus.o_IMAGE_SEL    = img_q;
  assign bus.o_BLANK        = blank_q;
  assign bus.o_FRAME_COMMIT = commit_q;

  // Accumulate requests; on a boundary commit them and restart pending with
  // only a press that lands in the boundary cycle itself.
  always_comb begin
    pend_cycle_d = pend_cycle_q | press_cycle;
    pend_blank_d = pend_blank_q ^ press_blank;
    img_d        = img_q;
    blank_d      = blank_q;
    commit_d     = 1'b0;
    if (boundary) begin
      commit_d = 1'b1;
      if (pend_cycle_q) img_d   = (img_q == IDX_LAST) ? '0 : img_q + 1'b1;
      if (pend_blank_q) blank_d = ~blank_q;
      pend_cycle_d = press_cycle;
      pend_blank_d = press_blank;
    end
  end

  // Vsync history, pending flags and committed outputs.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      vsync_q      <= 1'b1;
      pend_cycle_q <= 1'b0;
      pend_blank_q <= 1'b0;
      img_q        <= '0;
      blank_q      <= 1'b0;
      commit_q     <= 1'b0;
    end else begin
      vsync_q      <= bus.i_VGA_VSYNC;
      pend_cycle_q <= pend_cycle_d;
      pend_blank_q <= pend_blank_d;
      img_q        <= img_d;
      blank_q      <= blank_d;
      commit_q     <= commit_d;
    end
  end

endmodule : vga_button_control

// File: tb/tb_vga_button_control.sv
// Directed bench for vga_button_control with a commit scoreboard: each
// expected committed state is queued before its frame boundary and popped
// when the commit pulse appears.
module tb_vga_button_control;
  import vga_button_control_pkg::*;

  localparam int DEB          = 4;
  localparam int NIMG         = 3;
  localparam int FRAME        = 100;
  localparam int VS_LOW_START = 96;

  typedef struct packed {
    image_idx_t img;
    logic       blank;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  vga_button_control_if #(.IMAGE_COUNT(NIMG)) bus ();

  vga_button_control #(
    .DEBOUNCE_CYCLES  (DEB),
    .IMAGE_COUNT      (NIMG),
    .BUTTON_ACTIVE_LOW(1'b1)
  ) dut (
    .i_CLK  (clk),
    .i_RST_N(rst_n),
    .bus    (bus.slave)
  );

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         pass_cnt  = 0;
  int         chk_cnt   = 0;
  int         vs_cnt    = 0;
  bit         mon_en    = 1'b0;
  image_idx_t cur_img   = '0;
  logic       cur_blank = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed=%0h expected=%0h (vs_cnt=%0d)", tag, obs, exp, vs_cnt);
  endtask

  // One clock; vsync low for the last four cycles of each 100-cycle frame.
  task automatic tick();
    @(posedge clk);
    #1;
    vs_cnt = (vs_cnt + 1) % FRAME;
    bus.i_VGA_VSYNC = (vs_cnt >= VS_LOW_START) ? 1'b0 : 1'b1;
  endtask

  task automatic wait_vs(input int target);
    for (int i = 0; i < 2 * FRAME && vs_cnt != target; i++) tick();
    check("wait_vs_bound", 32'(vs_cnt), 32'(target));
  endtask

  // Queue the state the next boundary must commit, then run past it.
  task automatic expect_frame(input image_idx_t img, input logic blank);
    exp_q.push_back('{img: img, blank: blank});
    tick();
    wait_vs(VS_LOW_START + 2);
    check("commit_missing", 32'(exp_q.size()), 32'd0);
  endtask

  // Clean press: held low well past debounce, then released just as long.
  task automatic press(input bit blank_btn);
    if (blank_btn) bus.i_BLANK_DISPLAY = 1'b0;
    else           bus.i_CYCLE_IMAGE   = 1'b0;
    repeat (10) tick();
    bus.i_BLANK_DISPLAY = 1'b1;
    bus.i_CYCLE_IMAGE   = 1'b1;
    repeat (10) tick();
  endtask

  // Output monitor: commit pulse only one cycle after each vsync fall, and
  // the committed state never moves except on a commit.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      check("commit_timing", 32'(bus.o_FRAME_COMMIT), 32'(vs_cnt == VS_LOW_START + 1));
      if (bus.o_FRAME_COMMIT === 1'b1) begin
        check("commit_unexpected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_e     = exp_q.pop_front();
          cur_img   = mon_e.img;
          cur_blank = mon_e.blank;
        end
      end
      check("image_sel", 32'(bus.o_IMAGE_SEL), 32'(cur_img));
      check("blank",     32'(bus.o_BLANK),     32'(cur_blank));
    end
  end

  initial begin
    bus.i_CYCLE_IMAGE   = 1'b1;
    bus.i_BLANK_DISPLAY = 1'b1;
    bus.i_VGA_VSYNC     = 1'b1;
    rst_n               = 1'b0;
    repeat (3) tick();
    check("rst_image_sel", 32'(bus.o_IMAGE_SEL),    32'd0);
    check("rst_blank",     32'(bus.o_BLANK),        32'd0);
    check("rst_commit",    32'(bus.o_FRAME_COMMIT), 32'd0);
    rst_n = 1'b1;
    tick();
    mon_en = 1'b1;

    // First boundary after reset: pulse only, no state change.
    expect_frame(2'd0, 1'b0);

    // Single cycle press advances at the next boundary.
    press(1'b0);
    expect_frame(2'd1, 1'b0);

    // Bouncing contact never stays stable long enough to register.
    for (int i = 0; i < 5; i++) begin
      bus.i_CYCLE_IMAGE = 1'b0;
      repeat (2) tick();
      bus.i_CYCLE_IMAGE = 1'b1;
      repeat (2) tick();
    end
    repeat (10) tick();
    expect_frame(2'd1, 1'b0);

    // Clean presses over three frames, including the wrap to 0.
    press(1'b0);
    expect_frame(2'd2, 1'b0);
    press(1'b0);
    expect_frame(2'd0, 1'b0);
    press(1'b0);
    expect_frame(2'd1, 1'b0);

    // Two blank presses in one frame cancel; one press blanks.
    press(1'b1);
    press(1'b1);
    expect_frame(2'd1, 1'b0);
    press(1'b1);
    expect_frame(2'd1, 1'b1);

    // Cycling while blanked still advances the image.
    press(1'b0);
    expect_frame(2'd2, 1'b1);

    // Both requests in one frame commit together (image wraps, unblank).
    press(1'b0);
    press(1'b1);
    expect_frame(2'd0, 1'b0);

    // Press event lands in the boundary cycle: deferred one frame.
    wait_vs(VS_LOW_START - DEB - 2);
    bus.i_CYCLE_IMAGE = 1'b0;
    expect_frame(2'd0, 1'b0);
    bus.i_CYCLE_IMAGE = 1'b1;
    repeat (10) tick();
    expect_frame(2'd1, 1'b0);

    // Press event one cycle before the boundary: committed by it.
    wait_vs(VS_LOW_START - DEB - 3);
    bus.i_CYCLE_IMAGE = 1'b0;
    expect_frame(2'd2, 1'b0);
    bus.i_CYCLE_IMAGE = 1'b1;
    repeat (10) tick();

    // Blank the display so the reset below clears a non-zero state.
    press(1'b1);
    expect_frame(2'd2, 1'b1);

    // Requests pending, then reset mid-frame discards everything.
    press(1'b0);
    press(1'b1);
    rst_n     = 1'b0;
    cur_img   = '0;
    cur_blank = 1'b0;
    #1;
    check("midrst_image_sel", 32'(bus.o_IMAGE_SEL),    32'd0);
    check("midrst_blank",     32'(bus.o_BLANK),        32'd0);
    check("midrst_commit",    32'(bus.o_FRAME_COMMIT), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    expect_frame(2'd0, 1'b0);

    repeat (5) tick();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule : tb_vga_button_control
